slide_data_sched: RTL

- Scheduler for the 4-lane Slide_Data datapath (7-bit lanes 0..3) feeding the B1 stage of the ECG accelerator.
- On a start pulse it walks one shared sample RAM and issues one read address per lane per beat. It produces 451 beats for lanes 0..2 and 449 for lane 3.
- It aligns per-lane valid flags to the RAM read latency, honours downstream back-pressure, and signals done.

---
 rtl/slide_pkg.sv | 22 ++
 rtl/slide_addr_gen.sv | 47 ++++
 rtl/slide_data_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/slide_pkg.sv
// Shared constants and state encoding for the Slide_Data scheduler.
//   SLIDE_LEN_FULL : beats per frame on lanes 0..2
//   SLIDE_LEN_LAST : beats per frame on lane 3 (<= SLIDE_LEN_FULL)
//   SLIDE_LANE_OFS : address stride between lane regions in the sample RAM
package slide_pkg;

    localparam int unsigned SLIDE_LANES    = 4;
    localparam int unsigned SLIDE_LEN_FULL = 451;
    localparam int unsigned SLIDE_LEN_LAST = 449;
    localparam int unsigned SLIDE_LANE_OFS = 451;
    localparam int unsigned SLIDE_DATA_W   = 7;
    localparam int unsigned SLIDE_ADDR_W   = 11;
    localparam int unsigned SLIDE_CNT_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } slide_state_e;

endpackage

// File: rtl/slide_addr_gen.sv
// Beat counter plus per-lane offset adders for the shared sample RAM.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : clear the beat counter (addresses hold)
//   en            : issue one beat: register lane addresses, advance counter
//   cnt           : index of the next beat to issue
//   rd_addr_0..3  : registered per-lane RAM addresses (lane*OFS + beat)
module slide_addr_gen
    import slide_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic [SLIDE_CNT_W-1:0]  cnt,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_0,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_1,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_2,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_3
);

    localparam logic [SLIDE_ADDR_W-1:0] OFS_1 = SLIDE_ADDR_W'(SLIDE_LANE_OFS);
    localparam logic [SLIDE_ADDR_W-1:0] OFS_2 = SLIDE_ADDR_W'(2 * SLIDE_LANE_OFS);
    localparam logic [SLIDE_ADDR_W-1:0] OFS_3 = SLIDE_ADDR_W'(3 * SLIDE_LANE_OFS);

    logic [SLIDE_ADDR_W-1:0] base;
    assign base = SLIDE_ADDR_W'(cnt);

    // Counter and address registers; clear has priority over issue
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rd_addr_0 <= '0;
            rd_addr_1 <= '0;
            rd_addr_2 <= '0;
            rd_addr_3 <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt       <= cnt + SLIDE_CNT_W'(1);
            rd_addr_0 <= base;
            rd_addr_1 <= OFS_1 + base;
            rd_addr_2 <= OFS_2 + base;
            rd_addr_3 <= OFS_3 + base;
        end
    end

endmodule

// File: rtl/slide_data_sched.sv
// Read scheduler for the 4-lane Slide_Data datapath feeding the B1 stage.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a frame (honoured only in IDLE)
//   abort         : return to IDLE at the next edge, no done pulse
//   out_ready     : downstream accepts a beat issued this cycle
//   rd_en         : RAM read strobe
//   rd_addr_0..3  : per-lane RAM addresses
//   lane_vld      : per-lane data valid, aligned with RAM data (1 cycle after rd_en)
//   beat_idx      : beat index of the data flagged by lane_vld
//   busy          : high from leaving IDLE until return to IDLE
//   done          : one-cycle pulse after the final lane_vld beat
module slide_data_sched
    import slide_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    out_ready,
    output logic                    rd_en,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_0,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_1,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_2,
    output logic [SLIDE_ADDR_W-1:0] rd_addr_3,
    output logic [SLIDE_LANES-1:0]  lane_vld,
    output logic [SLIDE_CNT_W-1:0]  beat_idx,
    output logic                    busy,
    output logic                    done
);

    slide_state_e           state;
    logic [SLIDE_CNT_W-1:0] cnt;
    logic                   issue;
    logic                   last_beat;
    logic                   cnt_clr;

    assign issue     = (state == RUN) && out_ready && !abort;
    assign last_beat = issue && (cnt == SLIDE_CNT_W'(SLIDE_LEN_FULL - 1));
    assign cnt_clr   = abort || ((state == IDLE) && start);

    slide_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (issue),
        .cnt       (cnt),
        .rd_addr_0 (rd_addr_0),
        .rd_addr_1 (rd_addr_1),
        .rd_addr_2 (rd_addr_2),
        .rd_addr_3 (rd_addr_3)
    );

    // FSM, read strobe and one-cycle valid pipeline.
    // Lane 0 has zero offset, so rd_addr_0 is the beat index of the read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            lane_vld <= '0;
            beat_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_en <= issue;
            done  <= 1'b0;

            // Abort discards the beat still in flight
            if (abort) begin
                lane_vld <= '0;
            end else begin
                lane_vld <= {rd_en && (rd_addr_0 < SLIDE_ADDR_W'(SLIDE_LEN_LAST)),
                             {(SLIDE_LANES - 1){rd_en}}};
            end
            if (rd_en && !abort) begin
                beat_idx <= SLIDE_CNT_W'(rd_addr_0);
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last_beat) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= !abort;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
